bit_scan_encoder: RTL and testbench
===================================

Name: bit_scan_encoder

Overview:
Sequential multi-hit encoder. It accepts an M-bit request vector through a valid/ready handshake and emits the index of every set bit, one per output beat, in LSB-first or MSB-first order. It also reports the total set-bit count and flags the last beat and the all-zero case. It sits between status/interrupt vectors and serial consumers, such as arbiters, IRQ dispatch and event loggers, that need every asserted position rather than just one.

Parameters:
M, 16, request vector width; legal range M >= 2.
MSB_FIRST, 0, 0 = emit indices in ascending order; 1 = emit in descending order.
N (localparam), $clog2(M), index width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous and active-high.
in_valid  input  1  in_vec is valid.
in_ready  output  1  block can accept a vector; high only in IDLE.
in_vec  input  M  request vector.
out_valid  output  1  out_idx, out_last and out_zero are valid.
out_ready  input  1  consumer takes the current beat.
out_idx  output  N  index of the current set bit; 0 on a zero beat.
out_last  output  1  current beat is the final beat for this vector.
out_zero  output  1  accepted vector was all zeros (single beat).
out_total  output  N+1  popcount of the accepted vector; held from accept until the next accept.

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, out_zero=0, out_total=0.
  - in_ready=1 in the cycle after the reset edge.
- rst has priority over every other event, including a handshake in the same cycle. Reset in EMIT discards the pending vector; no further beats for it.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready at an edge.
  - On accept: pending <= in_vec, out_total <= popcount(in_vec), state <= EMIT.
  - in_vec is sampled only at the accept edge; changes at other times are ignored.
- State EMIT:
  - in_ready=0, out_valid=1.
  - Latency: first beat is visible the cycle after the accept edge.
  - out_idx = lowest set bit of pending (MSB_FIRST=0) or highest set bit (MSB_FIRST=1).
  - out_last=1 when pending has exactly one set bit, or when pending is zero.
  - out_zero=1 when pending is zero.
  - out_idx, out_last and out_zero are functions of registered state only; there is no combinational path from in_* or out_ready to any output.
  - Beat transfer = out_valid && out_ready at an edge. On transfer:
    - if out_last: state <= IDLE, pending <= 0;
    - else: the emitted bit is cleared in pending, other bits unchanged.
  - Without out_ready: out_valid stays 1 and outputs are held stable (no drop, no skip).
- Zero vector: exactly one beat with out_zero=1, out_last=1, out_idx=0, out_total=0.
- Full vector (all ones): M beats, indices 0..M-1 (or M-1..0); out_total=M; N+1 bits is sufficient at M a power of two.
- Back-to-back vectors: a new accept is not possible in the same cycle as the last beat transfer. in_ready rises the cycle after, so minimum throughput is (popcount + 1) cycles per vector, or 2 cycles for a zero vector.
- Beat count per vector = max(1, popcount).
- in_valid while in_ready=0 is ignored; the producer must hold the vector until accepted.

Test Plan:
1. Reset then idle: rst high 2 cycles, in_valid=0 -> in_ready=1, out_valid=0, all outputs 0.
2. M=16, MSB_FIRST=0, in_vec=16'h8421, out_ready=1 -> accept, then beats out_idx=0,5,10,15 on consecutive cycles; out_last only on 15; out_total=4; in_ready=1 the cycle after.
3. Same vector, MSB_FIRST=1, out_ready toggling 1,0,1,0,... -> order 15,10,5,0; each beat held stable while out_ready=0; total 4 transfers.
4. in_vec=16'h0000 -> one beat with out_zero=1, out_last=1, out_idx=0, out_total=0; then IDLE. in_vec=16'hFFFF -> 16 beats 0..15, out_total=16.
5. Reset mid-operation: accept 16'h00F0, transfer beat idx=4, assert rst with out_ready=1 -> no further beats; out_valid=0, in_ready=1 after the reset edge; next vector 16'h0002 yields the single beat idx=1.
6. Back-to-back: in_valid held high with 16'h0001 then 16'h0003 -> beats 0 (last); in_ready low in that cycle; next accept one cycle later; beats 0, 1 (last). Randomised stress checks beat count = max(1, popcount) and index order against a model.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// -----------------------------------------------------------------------------
// bit_scan_encoder
//
// Sequential multi-hit encoder. An M-bit request vector is accepted through a
// valid/ready handshake. The block then emits the index of every set bit, one
// index per output beat. The order is LSB-first, or MSB-first when MSB_FIRST=1.
// The popcount of the vector is reported for the whole operation. An all-zero
// vector produces a single beat that is flagged with out_zero.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_vec is valid
//   in_ready   block can accept a vector (high only in IDLE)
//   in_vec     request vector
//   out_valid  out_idx / out_last / out_zero are valid
//   out_ready  consumer takes the current beat
//   out_idx    index of the current set bit (0 on a zero beat)
//   out_last   current beat is the final beat for this vector
//   out_zero   accepted vector was all zeros
//   out_total  popcount of the accepted vector; held until the next accept
// -----------------------------------------------------------------------------
module bit_scan_encoder #(
    parameter int  M         = 16,
    parameter bit  MSB_FIRST = 1'b0,
    localparam int N         = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_idx,
    output logic         out_last,
    output logic         out_zero,
    output logic [N:0]   out_total
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       state;
    logic [M-1:0] pending;
    logic [M-1:0] cleared;

    // This function returns the index of the next bit to emit. In ascending mode
    // that is the lowest set bit. In descending mode it is the highest set bit.
    // The loop lets the wanted bit overwrite every earlier candidate.
    function automatic logic [N-1:0] scan_idx(input logic [M-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int i = 0; i < M; i++) begin
            if (MSB_FIRST) begin
                if (v[i]) idx = N'(i);
            end else begin
                if (v[M-1-i]) idx = N'(M-1-i);
            end
        end
        return idx;
    endfunction

    function automatic logic [N:0] pop_count(input logic [M-1:0] v);
        logic [N:0] cnt;
        cnt = '0;
        for (int i = 0; i < M; i++) begin
            cnt = cnt + {{N{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // The result is true when v has zero set bits or exactly one set bit.
    // Either case makes the current beat the last beat.
    function automatic logic at_most_one(input logic [M-1:0] v);
        return (v & (v - M'(1))) == '0;
    endfunction

    // This is the pending vector with the bit currently on out_idx removed.
    // It becomes the next pending vector after a non-final beat transfers.
    assign cleared   = pending & ~(M'(1) << out_idx);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);

    // out_idx, out_last and out_zero are registered. Each one is computed from
    // the vector that will be pending next, so the outputs depend only on flops.
    // NOTE: every register here is assigned with <= so that all of them update
    // from the values that existed before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this reset is synchronous and has priority over any handshake
            // in the same cycle. A vector that was still being emitted is dropped.
            state     <= IDLE;
            pending   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_zero  <= 1'b0;
            out_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pending   <= in_vec;
                        out_total <= pop_count(in_vec);
                        out_idx   <= scan_idx(in_vec);
                        out_last  <= at_most_one(in_vec);
                        out_zero  <= (in_vec == '0);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state    <= IDLE;
                            pending  <= '0;
                            out_idx  <= '0;
                            out_last <= 1'b0;
                            out_zero <= 1'b0;
                        end else begin
                            pending  <= cleared;
                            out_idx  <= scan_idx(cleared);
                            out_last <= at_most_one(cleared);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_bit_scan_encoder
//
// This bench drives two encoders from the same stimulus. One instance has
// MSB_FIRST=0 and the other has MSB_FIRST=1, so both emit in lockstep. When a
// vector is driven, the expected beats for each instance are queued. A negedge
// monitor pops the queues and compares them with every beat that transfers.
// -----------------------------------------------------------------------------
module tb_bit_scan_encoder;

    localparam int M = 16;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] idx;
        logic         last;
        logic         zero;
        logic [N:0]   total;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [M-1:0] in_vec;
    logic         out_ready;

    logic         in_ready [2];
    logic         ov       [2];
    logic [N-1:0] oi       [2];
    logic         ol       [2];
    logic         oz       [2];
    logic [N:0]   ot       [2];

    beat_t q0[$];
    beat_t q1[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int last_cyc = 0;
    int n_xfer   [2];
    int xfer_cyc [$];

    // out_ready source: 0 = constant rdy_const, 1 = toggle, 2 = random
    int   rdy_mode  = 0;
    logic rdy_const = 1'b1;

    logic         held [2];
    logic [N-1:0] h_idx[2];
    logic         h_last[2];
    logic         h_zero[2];

    bit_scan_encoder #(.M(M), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_vec(in_vec), .out_valid(ov[0]), .out_ready(out_ready),
        .out_idx(oi[0]), .out_last(ol[0]), .out_zero(oz[0]), .out_total(ot[0])
    );

    bit_scan_encoder #(.M(M), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_vec(in_vec), .out_valid(ov[1]), .out_ready(out_ready),
        .out_idx(oi[1]), .out_last(ol[1]), .out_zero(oz[1]), .out_total(ot[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // out_ready driver, updated 1 time unit after each rising edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = rdy_const;
            endcase
        end
    end

    // Monitor: on the falling edge, check held beats, then score transfers
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                held[d] = 1'b0;
            end else if (ov[d]) begin
                beat_t e;
                logic  have;
                check("in_ready_low_while_emitting", in_ready[d], 1'b0);
                if (held[d]) begin
                    check("hold_idx",  oi[d], h_idx[d]);
                    check("hold_last", ol[d], h_last[d]);
                    check("hold_zero", oz[d], h_zero[d]);
                end
                if (!out_ready) begin
                    held[d]   = 1'b1;
                    h_idx[d]  = oi[d];
                    h_last[d] = ol[d];
                    h_zero[d] = oz[d];
                end else begin
                    held[d] = 1'b0;
                    n_xfer[d]++;
                    if (d == 0) begin
                        xfer_cyc.push_back(cyc);
                        if (ol[0]) last_cyc = cyc;
                    end
                    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    check("beat_was_expected", have, 1'b1);
                    if (have) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check(d == 0 ? "lsb_idx"   : "msb_idx",   oi[d], e.idx);
                        check(d == 0 ? "lsb_last"  : "msb_last",  ol[d], e.last);
                        check(d == 0 ? "lsb_zero"  : "msb_zero",  oz[d], e.zero);
                        check(d == 0 ? "lsb_total" : "msb_total", ot[d], e.total);
                    end
                end
            end else begin
                held[d] = 1'b0;
            end
        end
    end

    // Reference model: queue the beats that each instance should emit for v
    task automatic push_model(input logic [M-1:0] v);
        int cnt;
        int k;
        cnt = $countones(v);
        if (cnt == 0) begin
            q0.push_back('{4'd0, 1'b1, 1'b1, 5'd0});
            q1.push_back('{4'd0, 1'b1, 1'b1, 5'd0});
        end else begin
            k = 0;
            for (int i = 0; i < M; i++) begin
                if (v[i]) begin
                    k++;
                    q0.push_back('{4'(i), (k == cnt), 1'b0, 5'(cnt)});
                end
            end
            k = 0;
            for (int i = M - 1; i >= 0; i--) begin
                if (v[i]) begin
                    k++;
                    q1.push_back('{4'(i), (k == cnt), 1'b0, 5'(cnt)});
                end
            end
        end
    endtask

    // Present v and return 1 time unit after the edge that accepts it.
    // in_valid is left high, so the caller either drops it or sends again.
    task automatic send(input logic [M-1:0] v);
        logic accepted;
        in_vec   = v;
        in_valid = 1'b1;
        push_model(v);
        accepted = 1'b0;
        for (int t = 0; t < 500 && !accepted; t++) begin
            @(negedge clk);
            if (in_ready[0]) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            @(posedge clk);
            #1;
        end
        check("accept_within_budget", accepted, 1'b1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !ov[0] && !ov[1]) done = 1'b1;
        end
        check("drain_within_budget", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int expect_beats;
        logic [M-1:0] v;
        n_xfer[0] = 0;
        n_xfer[1] = 0;
        held[0]   = 1'b0;
        held[1]   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;

        // 1: reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  in_ready[0], 1'b1);
        check("rst_out_valid", ov[0], 1'b0);
        check("rst_out_idx",   oi[0], 4'd0);
        check("rst_out_last",  ol[0], 1'b0);
        check("rst_out_zero",  oz[0], 1'b0);
        check("rst_out_total", ot[0], 5'd0);
        @(posedge clk);
        #1;

        // 2: 16'h8421 with out_ready held high. Check beats on consecutive cycles.
        xfer_cyc.delete();
        send(16'h8421);
        in_valid = 1'b0;
        drain();
        check("t2_beat_count", xfer_cyc.size(), 4);
        for (int k = 0; k < xfer_cyc.size(); k++)
            check("t2_beat_cycle", xfer_cyc[k], acc_cyc + 1 + k);
        check("t2_in_ready_after", in_ready[0], 1'b1);

        // 3: toggling out_ready. The monitor checks order and stalled beats.
        rdy_mode  = 1;
        n_xfer[1] = 0;
        send(16'h8421);
        in_valid = 1'b0;
        drain();
        check("t3_msb_transfers", n_xfer[1], 4);
        rdy_mode = 0;

        // 4: zero vector, then full vector
        n_xfer[0] = 0;
        send(16'h0000);
        in_valid = 1'b0;
        drain();
        check("t4_zero_beats", n_xfer[0], 1);
        n_xfer[0] = 0;
        send(16'hFFFF);
        in_valid = 1'b0;
        drain();
        check("t4_full_beats", n_xfer[0], 16);

        // 5: reset arrives after the first beat of 16'h00F0
        send(16'h00F0);
        in_valid = 1'b0;
        @(posedge clk);   // the first beat transfers on this edge
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_out_valid_after_rst", ov[0], 1'b0);
        check("t5_in_ready_after_rst",  in_ready[0], 1'b1);
        check("t5_beats_left_lsb", q0.size(), 3);
        check("t5_beats_left_msb", q1.size(), 3);
        q0.delete();
        q1.delete();
        send(16'h0002);
        in_valid = 1'b0;
        drain();

        // 6: back-to-back vectors with in_valid held high
        send(16'h0001);
        send(16'h0003);
        in_valid = 1'b0;
        check("t6_b2b_gap", acc_cyc - last_cyc, 1);
        drain();

        // 7: random stress with random out_ready and random idle gaps
        rdy_mode     = 2;
        n_xfer[0]    = 0;
        n_xfer[1]    = 0;
        expect_beats = 0;
        for (int n = 0; n < 60; n++) begin
            v = M'($urandom);
            if ($urandom_range(0, 7) == 0) v = '0;
            if ($urandom_range(0, 7) == 0) v = v & M'($urandom);
            expect_beats += ($countones(v) == 0) ? 1 : $countones(v);
            send(v);
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();
        check("t7_lsb_beat_total", n_xfer[0], expect_beats);
        check("t7_msb_beat_total", n_xfer[1], expect_beats);
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
